// File: rtl/keylock_ctrl.sv
// keylock_ctrl: keypad lock controller.
// Collects debounced key strobes into a code buffer, matches it against the
// stored code, runs the lock/unlock and three-step reprogram sequences, times
// the ok/err indications and enforces a lockout after repeated failures.
//
// Optional feature macro: AUTO_RELOCK_EN
//   When defined, the controller relocks itself after RELOCK_CYCLES idle cycles
//   spent unlocked in IDLE. When undefined, that counting logic is not built.
//
// Input handshake: key_valid is a single-cycle strobe qualifying key; there is
// no ready. A strobe is consumed on the clock edge where it is high, unless the
// FSM is in OK_BLINK, ERR_BLINK or LOCKOUT, where it is dropped.
//
// All outputs are registered from next-state values, so the effect of a key
// accepted at edge N is visible right after edge N.

module keylock_ctrl #(
    parameter int CODE_LEN                          = 4,
    parameter int KEY_W                             = 4,
    parameter int KEY_LOCK                          = 9,
    parameter int KEY_PROG                          = 8,
    parameter int KEY_CANCEL                        = 7,
    parameter logic [CODE_LEN*KEY_W-1:0] RESET_CODE = 16'h1234,
    parameter int BLINK_CYCLES                      = 25000000,
    parameter int MAX_FAIL                          = 3,
    parameter int LOCKOUT_CYCLES                    = 250000000,
    parameter int RELOCK_CYCLES                     = 500000000
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              key_valid,
    input  logic [KEY_W-1:0]                  key,
    output logic                              locked,
    output logic                              led_ok,
    output logic                              led_err,
    output logic                              lockout,
    output logic                              busy,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int CODE_W   = CODE_LEN * KEY_W;
    localparam int DCW      = $clog2(CODE_LEN + 1);
    localparam int FCW      = $clog2(MAX_FAIL + 1);
    // One shared down-counter serves blink, lockout and relock timing.
    localparam int T_MAX_BL = (BLINK_CYCLES > LOCKOUT_CYCLES) ? BLINK_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX    = (T_MAX_BL > RELOCK_CYCLES) ? T_MAX_BL : RELOCK_CYCLES;
    localparam int TW       = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] BLINK_LD   = TW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
    localparam logic [TW-1:0] RELOCK_LD  = TW'(RELOCK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ENTER        = 3'd1,
        S_PROG_OLD     = 3'd2,
        S_PROG_NEW     = 3'd3,
        S_PROG_CONFIRM = 3'd4,
        S_OK_BLINK     = 3'd5,
        S_ERR_BLINK    = 3'd6,
        S_LOCKOUT      = 3'd7
    } state_t;

    state_t             r_state;
    logic               r_locked;
    logic               r_led_ok;
    logic               r_led_err;
    logic               r_lockout;
    logic               r_busy;
    logic [DCW-1:0]     r_digit_cnt;
    logic [FCW-1:0]     r_fail_cnt;
    logic               r_ovf;
    logic [CODE_W-1:0]  r_buf;
    logic [CODE_W-1:0]  r_cand;
    logic [CODE_W-1:0]  r_stored;
    logic [TW-1:0]      r_timer;

    state_t             w_state_nxt;
    logic               w_locked_nxt;
    logic [FCW-1:0]     w_fail_nxt;
    logic [FCW-1:0]     w_fail_inc;
    logic [TW-1:0]      w_timer_nxt;
    logic               w_digit_en;
    logic               w_cand_ld;
    logic               w_store_ld;
    logic               w_is_lock;
    logic               w_is_prog;
    logic               w_is_cancel;
    logic               w_is_digit;
    logic [CODE_W-1:0]  w_ref;
    logic               w_full;
    logic               w_match;

    assign w_is_lock   = (key == KEY_W'(KEY_LOCK));
    assign w_is_prog   = (key == KEY_W'(KEY_PROG));
    assign w_is_cancel = (key == KEY_W'(KEY_CANCEL));
    assign w_is_digit  = !(w_is_lock || w_is_prog || w_is_cancel);

    // Confirm step compares against the candidate, everything else against the stored code.
    assign w_ref   = (r_state == S_PROG_CONFIRM) ? r_cand : r_stored;
    assign w_full  = (r_digit_cnt == DCW'(CODE_LEN)) && !r_ovf;
    assign w_match = w_full && (r_buf == w_ref);

    assign w_fail_inc = (r_fail_cnt == FCW'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + FCW'(1);

    // Next-state, counter and control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_locked_nxt = r_locked;
        w_fail_nxt   = r_fail_cnt;
        w_timer_nxt  = r_timer;
        w_digit_en   = 1'b0;
        w_cand_ld    = 1'b0;
        w_store_ld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
`ifdef AUTO_RELOCK_EN
                // Zero means the idle count has not started yet; a key restarts it.
                if (!r_locked) begin
                    if (key_valid || (r_timer == '0)) begin
                        w_timer_nxt = RELOCK_LD;
                    end else if (r_timer == TW'(1)) begin
                        w_timer_nxt  = '0;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
`endif
                if (key_valid && w_is_lock) begin
                    w_state_nxt = S_ENTER;
                    w_timer_nxt = '0;
                end else if (key_valid && w_is_prog) begin
                    if (!r_locked) begin
                        w_state_nxt = S_PROG_OLD;
                        w_timer_nxt = '0;
                    end else begin
                        w_state_nxt = S_ERR_BLINK;
                        w_timer_nxt = BLINK_LD;
                    end
                end
            end
            S_ENTER: begin
                w_timer_nxt = '0;
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_digit_en = 1'b1;
                    end else if (w_is_cancel) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_lock) begin
                        w_timer_nxt = BLINK_LD;
                        if (w_match) begin
                            w_locked_nxt = !r_locked;
                            w_fail_nxt   = '0;
                            w_state_nxt  = S_OK_BLINK;
                        end else begin
                            w_fail_nxt  = w_fail_inc;
                            w_state_nxt = S_ERR_BLINK;
                        end
                    end
                end
            end
            S_PROG_OLD: begin
                w_timer_nxt = '0;
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_digit_en = 1'b1;
                    end else if (w_is_cancel) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_prog) begin
                        if (w_match) begin
                            w_fail_nxt  = '0;
                            w_state_nxt = S_PROG_NEW;
                        end else begin
                            w_fail_nxt  = w_fail_inc;
                            w_state_nxt = S_ERR_BLINK;
                            w_timer_nxt = BLINK_LD;
                        end
                    end
                end
            end
            S_PROG_NEW: begin
                w_timer_nxt = '0;
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_digit_en = 1'b1;
                    end else if (w_is_cancel) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_prog) begin
                        if (w_full) begin
                            w_cand_ld   = 1'b1;
                            w_state_nxt = S_PROG_CONFIRM;
                        end else begin
                            w_state_nxt = S_ERR_BLINK;
                            w_timer_nxt = BLINK_LD;
                        end
                    end
                end
            end
            S_PROG_CONFIRM: begin
                w_timer_nxt = '0;
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_digit_en = 1'b1;
                    end else if (w_is_cancel) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_prog) begin
                        w_timer_nxt = BLINK_LD;
                        if (w_match) begin
                            w_store_ld  = 1'b1;
                            w_state_nxt = S_OK_BLINK;
                        end else begin
                            w_state_nxt = S_ERR_BLINK;
                        end
                    end
                end
            end
            S_OK_BLINK: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            S_ERR_BLINK: begin
                // fail_cnt only sits at MAX_FAIL here when the entering fail saturated it.
                if (r_timer == '0) begin
                    if (r_fail_cnt == FCW'(MAX_FAIL)) begin
                        w_state_nxt = S_LOCKOUT;
                        w_timer_nxt = LOCKOUT_LD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                    w_fail_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, timer, codes and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_locked    <= 1'b0;
            r_led_ok    <= 1'b0;
            r_led_err   <= 1'b0;
            r_lockout   <= 1'b0;
            r_busy      <= 1'b0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
            r_cand      <= '0;
            r_stored    <= RESET_CODE;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= w_locked_nxt;
            r_led_ok    <= (w_state_nxt == S_OK_BLINK);
            r_led_err   <= (w_state_nxt == S_ERR_BLINK);
            r_lockout   <= (w_state_nxt == S_LOCKOUT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_fail_cnt  <= w_fail_nxt;
            r_timer     <= w_timer_nxt;
            if (w_cand_ld) begin
                r_cand <= r_buf;
            end
            if (w_store_ld) begin
                r_stored <= r_cand;
            end
        end
    end

    // Code buffer: cleared on every state change, otherwise shifts digits in until full.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_ovf       <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_ovf       <= 1'b0;
        end else if (w_digit_en) begin
            if (r_digit_cnt == DCW'(CODE_LEN)) begin
                r_ovf <= 1'b1;
            end else begin
                r_buf       <= {r_buf[CODE_W-KEY_W-1:0], key};
                r_digit_cnt <= r_digit_cnt + DCW'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign led_ok    = r_led_ok;
    assign led_err   = r_led_err;
    assign lockout   = r_lockout;
    assign busy      = r_busy;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_keylock_ctrl.sv
// tb_keylock_ctrl: directed bench for keylock_ctrl with short timing parameters.
// Expected output snapshots {locked, led_ok, led_err, lockout, busy, digit_cnt,
// fail_cnt} are queued as each step is driven and checked one cycle later.

module tb_keylock_ctrl;

    localparam int CODE_LEN = 4;
    localparam int KEY_W    = 4;
    localparam int BLINK    = 4;
    localparam int MAXF     = 3;
    localparam int LOCKOUT  = 10;
    localparam int RELOCK   = 20;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       locked, led_ok, led_err, lockout, busy;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    keylock_ctrl #(
        .CODE_LEN       (CODE_LEN),
        .KEY_W          (KEY_W),
        .KEY_LOCK       (9),
        .KEY_PROG       (8),
        .KEY_CANCEL     (7),
        .RESET_CODE     (16'h1234),
        .BLINK_CYCLES   (BLINK),
        .MAX_FAIL       (MAXF),
        .LOCKOUT_CYCLES (LOCKOUT),
        .RELOCK_CYCLES  (RELOCK)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .key_valid (key_valid),
        .key       (key),
        .locked    (locked),
        .led_ok    (led_ok),
        .led_err   (led_err),
        .lockout   (lockout),
        .busy      (busy),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [9:0] st(input logic lk, input logic ok, input logic err,
                                      input logic lo, input logic bz, input int dc, input int fc);
        return {lk, ok, err, lo, bz, 3'(dc), 2'(fc)};
    endfunction

    // Scoreboard check: pop the oldest expectation and compare with the outputs.
    task automatic compare(input string tag);
        logic [9:0] got;
        logic [9:0] e;
        got = {locked, led_ok, led_err, lockout, busy, digit_cnt, fail_cnt};
        e = exp_q.pop_front();
        n_vec++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (lk ok err lo busy dc[3] fc[2])", tag, got, e);
        end
    endtask

    // One clock: optionally strobe a key, then check outputs just after the edge.
    task automatic step(input logic vld, input logic [3:0] k, input logic [9:0] e, input string tag);
        @(negedge clk);
        key_valid = vld;
        key       = k;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        compare(tag);
    endtask

    // Feed n digits (first digit in the most significant nibble used).
    task automatic digits(input logic [31:0] d, input int n, input logic lk,
                          input int dc0, input int fc, input string tag);
        int dcv;
        for (int i = 0; i < n; i++) begin
            dcv = dc0 + i + 1;
            if (dcv > CODE_LEN) dcv = CODE_LEN;
            step(1'b1, d[4*(n-1-i) +: 4], st(lk, 1'b0, 1'b0, 1'b0, 1'b1, dcv, fc), tag);
        end
    endtask

    // Start key, digits, submit key with the required post-submit snapshot.
    task automatic attempt(input logic [3:0] start_k, input logic [31:0] d, input int n,
                           input logic [3:0] submit_k, input logic lk, input int fc,
                           input logic [9:0] e_submit, input string tag);
        step(1'b1, start_k, st(lk, 1'b0, 1'b0, 1'b0, 1'b1, 0, fc), tag);
        digits(d, n, lk, 0, fc, tag);
        step(1'b1, submit_k, e_submit, tag);
    endtask

    // Remaining BLINK-1 cycles of an LED indication after the entry cycle.
    task automatic blink_tail(input logic ok, input logic err, input logic lk,
                              input int fc, input string tag);
        for (int i = 1; i < BLINK; i++) begin
            step(1'b0, 4'd0, st(lk, ok, err, 1'b0, 1'b1, 0, fc), tag);
        end
    endtask

    initial begin
        // Reset state.
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(st(0, 0, 0, 0, 0, 0, 0));
        compare("reset_state");
        @(negedge clk);
        resetN = 1'b1;

        // Lock, then unlock with the reset code.
        attempt(4'd9, 32'h1234, 4, 4'd9, 1'b0, 0, st(1, 1, 0, 0, 1, 0, 0), "lock");
        blink_tail(1'b1, 1'b0, 1'b1, 0, "lock_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 0), "lock_led_end");
        attempt(4'd9, 32'h1234, 4, 4'd9, 1'b1, 0, st(0, 1, 0, 0, 1, 0, 0), "unlock");
        blink_tail(1'b1, 1'b0, 1'b0, 0, "unlock_led");
        step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "unlock_led_end");

        // Reprogram 1234 -> 5601.
        attempt(4'd8, 32'h1234, 4, 4'd8, 1'b0, 0, st(0, 0, 0, 0, 1, 0, 0), "prog_old");
        digits(32'h5601, 4, 1'b0, 0, 0, "prog_new");
        step(1'b1, 4'd8, st(0, 0, 0, 0, 1, 0, 0), "prog_new_submit");
        digits(32'h5601, 4, 1'b0, 0, 0, "prog_confirm");
        step(1'b1, 4'd8, st(0, 1, 0, 0, 1, 0, 0), "prog_confirm_submit");
        blink_tail(1'b1, 1'b0, 1'b0, 0, "prog_led");
        step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "prog_led_end");
        attempt(4'd9, 32'h1234, 4, 4'd9, 1'b0, 0, st(0, 0, 1, 0, 1, 0, 1), "old_code_rejected");
        blink_tail(1'b0, 1'b1, 1'b0, 1, "old_code_led");
        step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 1), "old_code_led_end");
        attempt(4'd9, 32'h5601, 4, 4'd9, 1'b0, 1, st(1, 1, 0, 0, 1, 0, 0), "new_code_locks");
        blink_tail(1'b1, 1'b0, 1'b1, 0, "new_code_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 0), "new_code_led_end");

        // Three wrong codes -> lockout for exactly LOCKOUT cycles, keys ignored.
        for (int f = 1; f <= MAXF; f++) begin
            attempt(4'd9, 32'h1111, 4, 4'd9, 1'b1, f - 1, st(1, 0, 1, 0, 1, 0, f), "bad_code");
            blink_tail(1'b0, 1'b1, 1'b1, f, "bad_code_led");
            if (f < MAXF) step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, f), "bad_code_led_end");
        end
        step(1'b0, 4'd0, st(1, 0, 0, 1, 1, 0, 3), "lockout_entry");
        for (int c = 1; c < LOCKOUT; c++) begin
            step(1'b1, (c % 2 == 1) ? 4'd9 : 4'd8, st(1, 0, 0, 1, 1, 0, 3), "lockout_hold");
        end
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 0), "lockout_exit");

        // Length errors and cancel.
        attempt(4'd9, 32'h123, 3, 4'd9, 1'b1, 0, st(1, 0, 1, 0, 1, 0, 1), "short_code");
        blink_tail(1'b0, 1'b1, 1'b1, 1, "short_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 1), "short_led_end");
        attempt(4'd9, 32'h12345, 5, 4'd9, 1'b1, 1, st(1, 0, 1, 0, 1, 0, 2), "overflow_code");
        blink_tail(1'b0, 1'b1, 1'b1, 2, "overflow_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 2), "overflow_led_end");
        step(1'b1, 4'd9, st(1, 0, 0, 0, 1, 0, 2), "cancel_start");
        digits(32'h12, 2, 1'b1, 0, 2, "cancel_digits");
        step(1'b1, 4'd7, st(1, 0, 0, 0, 0, 0, 2), "cancel");

        // Reprogram refused while locked, fail count untouched.
        step(1'b1, 4'd8, st(1, 0, 1, 0, 1, 0, 2), "prog_while_locked");
        blink_tail(1'b0, 1'b1, 1'b1, 2, "prog_locked_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 2), "prog_locked_led_end");

        // KEY_PROG inside ENTER is ignored; unlock clears fail count.
        step(1'b1, 4'd9, st(1, 0, 0, 0, 1, 0, 2), "enter_start");
        digits(32'h56, 2, 1'b1, 0, 2, "enter_digits");
        step(1'b1, 4'd8, st(1, 0, 0, 0, 1, 2, 2), "prog_in_enter_ignored");
        digits(32'h01, 2, 1'b1, 2, 2, "enter_digits");
        step(1'b1, 4'd9, st(0, 1, 0, 0, 1, 0, 0), "unlock_5601");
        blink_tail(1'b1, 1'b0, 1'b0, 0, "unlock_5601_led");
        step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "unlock_5601_led_end");

        // KEY_LOCK inside PROG_OLD is ignored; then reset mid-programming.
        step(1'b1, 4'd8, st(0, 0, 0, 0, 1, 0, 0), "prog2_start");
        digits(32'h56, 2, 1'b0, 0, 0, "prog2_digits");
        step(1'b1, 4'd9, st(0, 0, 0, 0, 1, 2, 0), "lock_in_prog_ignored");
        digits(32'h01, 2, 1'b0, 2, 0, "prog2_digits");
        step(1'b1, 4'd8, st(0, 0, 0, 0, 1, 0, 0), "prog2_old_ok");
        digits(32'h5, 1, 1'b0, 0, 0, "prog2_partial");
        @(negedge clk);
        resetN = 1'b0;
        #1;
        exp_q.push_back(st(0, 0, 0, 0, 0, 0, 0));
        compare("reset_mid_prog");
        @(negedge clk);
        resetN = 1'b1;
        attempt(4'd9, 32'h1234, 4, 4'd9, 1'b0, 0, st(1, 1, 0, 0, 1, 0, 0), "reset_code_restored");
        blink_tail(1'b1, 1'b0, 1'b1, 0, "restored_led");
        step(1'b0, 4'd0, st(1, 0, 0, 0, 0, 0, 0), "restored_led_end");

        // Idle while unlocked.
        attempt(4'd9, 32'h1234, 4, 4'd9, 1'b1, 0, st(0, 1, 0, 0, 1, 0, 0), "unlock_for_idle");
        blink_tail(1'b1, 1'b0, 1'b0, 0, "idle_led");
        step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "idle_entry");
`ifdef AUTO_RELOCK_EN
        for (int c = 1; c < 15; c++) step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "relock_wait");
        step(1'b1, 4'd1, st(0, 0, 0, 0, 0, 0, 0), "relock_restart_key");
        for (int c = 1; c <= RELOCK - 3; c++) step(1'b0, 4'd0, st(0, 0, 0, 0, 0, 0, 0), "relock_restarted");
        begin
            int w;
            w = 0;
            while (!locked && w < 6) begin
                @(posedge clk);
                #1;
                w++;
            end
        end
        exp_q.push_back(st(1, 0, 0, 0, 0, 0, 0));
        compare("relock_fired");
`else
        for (int c = 1; c <= RELOCK + 10; c++) begin
            step(c == 15, 4'd1, st(0, 0, 0, 0, 0, 0, 0), "no_relock");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keylock_ctrl.md
Name: keylock_ctrl

Overview:
Parametrised keypad lock controller. It takes debounced key strobes, collects a multi-digit code internally and compares it against a stored code. It handles lock/unlock and the three-step reprogram sequence (old code, new code, confirm), times the success/error indications and enforces a lockout after repeated failures. It sits between the keypad scanner and the LED/actuator drivers, replacing the external match comparator and external blink timer.

Parameters:
CODE_LEN, 4, digits per code (2..8)
KEY_W, 4, key code width in bits
KEY_LOCK, 9, lock/unlock start/submit key
KEY_PROG, 8, reprogram start/submit key
KEY_CANCEL, 7, abort key
RESET_CODE, 16'h1234, stored code after reset (CODE_LEN*KEY_W bits, first digit in MSBs)
BLINK_CYCLES, 25000000, cycles led_ok/led_err are held
MAX_FAIL, 3, consecutive failures that trigger lockout
LOCKOUT_CYCLES, 250000000, lockout duration in cycles
RELOCK_CYCLES, 500000000, idle-unlocked timeout (used only with the optional feature)

Ports:
clk  in  1  clock
resetN  in  1  reset
key_valid  in  1  one-cycle strobe, key is valid
key  in  KEY_W  key code
locked  out  1  lock state; 1 = locked
led_ok  out  1  success indication
led_err  out  1  error indication
lockout  out  1  lockout active
busy  out  1  state != IDLE
digit_cnt  out  $clog2(CODE_LEN+1)  digits collected, saturating
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. On reset, state=IDLE, stored code=RESET_CODE, locked=0, all other outputs 0, buffer and timers cleared. Reset mid-sequence discards any partial entry or programming.
- All outputs are registered. A key accepted at edge N produces its state or output change after edge N, with no further latency.
- Digit: any key other than KEY_LOCK, KEY_PROG or KEY_CANCEL.
- Digit handling: a digit shifts into the code buffer (left shift, new digit in LSBs) and digit_cnt increments. Once CODE_LEN digits are held, a further digit sets an overflow flag; the buffer and digit_cnt do not change.
- Match: true when digit_cnt==CODE_LEN, no overflow, and buffer==reference. The buffer and overflow flag clear on every state entry.
- Key acceptance: key_valid is ignored in OK_BLINK, ERR_BLINK and LOCKOUT.
- Failure: a fail increments fail_cnt, saturating at MAX_FAIL.
- States and transitions:
  - IDLE: KEY_LOCK -> ENTER. KEY_PROG -> PROG_OLD if locked=0, else ERR_BLINK with no fail. All other keys ignored.
  - ENTER: digit -> buffered. KEY_CANCEL -> IDLE. KEY_LOCK -> on match: locked toggles, fail_cnt=0, OK_BLINK; otherwise fail, ERR_BLINK. KEY_PROG is ignored.
  - PROG_OLD: digit -> buffered. KEY_CANCEL -> IDLE. KEY_PROG -> on match against the stored code: fail_cnt=0, PROG_NEW; otherwise fail, ERR_BLINK.
  - PROG_NEW: digit -> buffered. KEY_CANCEL -> IDLE. KEY_PROG with digit_cnt==CODE_LEN and no overflow -> candidate=buffer, PROG_CONFIRM; otherwise ERR_BLINK with no fail.
  - PROG_CONFIRM: digit -> buffered. KEY_CANCEL -> IDLE with the stored code unchanged. KEY_PROG -> on match against the candidate: stored=candidate, OK_BLINK; otherwise ERR_BLINK with no fail and the stored code unchanged.
  - OK_BLINK / ERR_BLINK: led_ok / led_err is high for exactly BLINK_CYCLES cycles, then IDLE. Exception: if ERR_BLINK was entered by a fail that brought fail_cnt to MAX_FAIL, the next state is LOCKOUT instead of IDLE.
  - LOCKOUT: lockout=1 for LOCKOUT_CYCLES cycles, then fail_cnt=0 and IDLE. locked is unchanged.
- KEY_LOCK in PROG_* states and KEY_PROG in ENTER are ignored (no state change).
- Timer: a single down-counter shared by the blink, lockout and relock functions, sized for the largest of the three.

Optional Feature:
AUTO_RELOCK_EN: when defined, an idle counter runs while state==IDLE and locked=0. Any key_valid reloads it. After RELOCK_CYCLES cycles with no key, locked becomes 1 with no LED indication. The counter is held at 0 in every other state and whenever locked=1. When not defined, locked changes only through ENTER, and no relock counter is synthesised.

Test Plan:
Bench parameters for all scenarios: CODE_LEN=4, RESET_CODE=16'h1234, BLINK_CYCLES=4, MAX_FAIL=3, LOCKOUT_CYCLES=10, RELOCK_CYCLES=20.
1. Lock and unlock: keys 9,1,2,3,4,9 -> locked 0->1, led_ok high for exactly 4 cycles, fail_cnt=0. Repeat the sequence -> locked=0.
2. Reprogram: keys 8,1,2,3,4,8,5,6,0,1,8,5,6,0,1,8 -> led_ok. Then 9,1,2,3,4,9 -> led_err and locked=0; 9,5,6,0,1,9 -> locked=1.
3. Lockout: three sequences of 9,1,1,1,1,9 -> fail_cnt=1,2,3; after the third led_err, lockout high for exactly 10 cycles. Keys sent during lockout are ignored; fail_cnt returns to 0 afterwards.
4. Length errors: 9,1,2,3,9 (short) -> led_err. 9,1,2,3,4,5,9 (overflow) -> led_err. 9,1,2,7 -> IDLE, no LED, fail_cnt unchanged.
5. Guards and reset: with locked=1, key 8 -> led_err with fail_cnt unchanged. resetN pulse after 8,1,2,3,4,8,5 -> IDLE, locked=0, stored code 1234 restored.
6. AUTO_RELOCK_EN defined, locked=0, IDLE, no keys for 20 cycles -> locked=1. A key at cycle 15 restarts the count. Macro undefined -> locked stays 0.
